// File: rtl/cpu_pkg.sv
// cpu_pkg: arbiter FSM encoding, access-type constants, default sizes and
// the byte-lane merge helper shared by the memory arbiter and its RAM.
package cpu_pkg;

  // 64 x 32-bit words (256 bytes) unless overridden.
  localparam int ADDR_W_DEF     = 6;
  localparam int STARVE_MAX_DEF = 4;

  // State names the access performed in the previous cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_I_RD = 2'd1,
    ST_D_RD = 2'd2,
    ST_D_WR = 2'd3
  } arb_state_e;

  // Access type as carried on d_we.
  localparam logic ACC_READ  = 1'b0;
  localparam logic ACC_WRITE = 1'b1;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_sp.sv
// mem_sp: single-port synchronous RAM, byte-enabled writes, 1-cycle read.
// Contents are never reset so a loader can preload them.
module mem_sp
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem_r [0:DEPTH-1];
  logic [31:0] rdata_r;

  // One access per cycle: a byte-masked write, or a read registered into rdata_r.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_r[addr] <= byte_merge(mem_r[addr], wdata, be);
    end else if (en) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between an instruction-fetch port
// and a data port. Data wins contention; with MEM_ARBITER_FAIRNESS_EN
// defined, an instruction request denied STARVE_MAX cycles in a row wins the
// next contention. Grants are combinational, read data returns one cycle later.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata
);

  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  logic [ADDR_W-1:0] i_idx_s;
  logic [ADDR_W-1:0] d_idx_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic              i_win_s;
  logic              d_win_s;
  logic              force_i_s;
  logic              mem_en_s;
  logic              mem_we_s;
  logic              i_rvalid_s;
  logic              d_rvalid_s;
  logic [31:0]       mem_rdata_s;
  logic [31:0]       i_hold_r;
  logic [31:0]       d_hold_r;

  // Byte offset and bits above the array wrap silently.
  assign i_idx_s = i_addr[ADDR_W+1:2];
  assign d_idx_s = d_addr[ADDR_W+1:2];

  logic unused_addr_s;
  assign unused_addr_s = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                           d_addr[31:ADDR_W+2], d_addr[1:0]};

`ifdef MEM_ARBITER_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt_r;

  // Count consecutive cycles the instruction side asked and lost, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_r <= '0;
    end else if (!i_req || i_gnt) begin
      starve_cnt_r <= '0;
    end else if (starve_cnt_r != CNT_W'(STARVE_MAX)) begin
      starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  assign force_i_s = (starve_cnt_r == CNT_W'(STARVE_MAX));
`else
  assign force_i_s = 1'b0;

  logic unused_starve_s;
  assign unused_starve_s = (STARVE_MAX > 0);
`endif

  // Pick this cycle's winner: data first unless the instruction side is starving.
  always_comb begin
    i_win_s = 1'b0;
    d_win_s = 1'b0;
    if (reset) begin
      i_win_s = 1'b0;
      d_win_s = 1'b0;
    end else if (d_req && !(force_i_s && i_req)) begin
      d_win_s = 1'b1;
    end else if (i_req) begin
      i_win_s = 1'b1;
    end else begin
      i_win_s = 1'b0;
      d_win_s = 1'b0;
    end
  end

  assign i_gnt = i_win_s;
  assign d_gnt = d_win_s;

  // Drive the single RAM port from whichever side won.
  assign mem_en_s   = i_win_s | d_win_s;
  assign mem_we_s   = d_win_s & (d_we == ACC_WRITE);
  assign mem_addr_s = d_win_s ? d_idx_s : i_idx_s;

  mem_sp #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .en   (mem_en_s),
    .we   (mem_we_s),
    .be   (d_be),
    .addr (mem_addr_s),
    .wdata(d_wdata),
    .rdata(mem_rdata_s)
  );

  // Next state records which access this cycle's arbitration started.
  always_comb begin
    state_nxt_s = ST_IDLE;
    if (d_win_s) begin
      state_nxt_s = (d_we == ACC_READ) ? ST_D_RD : ST_D_WR;
    end else if (i_win_s) begin
      state_nxt_s = ST_I_RD;
    end else begin
      state_nxt_s = ST_IDLE;
    end
  end

  // State register; reset discards any read still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Read-return strobes decode directly from the state register.
  always_comb begin
    i_rvalid_s = 1'b0;
    d_rvalid_s = 1'b0;
    case (state_r)
      ST_I_RD: i_rvalid_s = 1'b1;
      ST_D_RD: d_rvalid_s = 1'b1;
      ST_IDLE, ST_D_WR: begin
        i_rvalid_s = 1'b0;
        d_rvalid_s = 1'b0;
      end
      default: begin
        i_rvalid_s = 1'b0;
        d_rvalid_s = 1'b0;
      end
    endcase
  end

  assign i_rvalid = i_rvalid_s;
  assign d_rvalid = d_rvalid_s;

  // Remember the last instruction word returned so i_rdata holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_hold_r <= 32'h0000_0000;
    end else if (i_rvalid_s) begin
      i_hold_r <= mem_rdata_s;
    end else begin
      i_hold_r <= i_hold_r;
    end
  end

  // Remember the last data word returned so d_rdata holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_hold_r <= 32'h0000_0000;
    end else if (d_rvalid_s) begin
      d_hold_r <= mem_rdata_s;
    end else begin
      d_hold_r <= d_hold_r;
    end
  end

  assign i_rdata = i_rvalid_s ? mem_rdata_s : i_hold_r;
  assign d_rdata = d_rvalid_s ? mem_rdata_s : d_hold_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// word-array memory model with a simple priority/starvation rule.
module tb_mem_arbiter;

  localparam int ADDR_W     = 6;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << ADDR_W;
`ifdef MEM_ARBITER_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] mm [DEPTH];
  int          starve;
  bit          exp_iv, exp_dv;
  logic [31:0] exp_ird, exp_drd;
  bit          eg_i, eg_d;

  mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_gnt   (i_gnt),
    .i_rvalid(i_rvalid),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_be    (d_be),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_gnt   (d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata (d_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'(DEPTH));
  endfunction

  // Expected grants for the inputs currently applied.
  function automatic void predict();
    bit force_i;
    force_i = FAIR && (starve >= STARVE_MAX);
    eg_d = !reset && d_req && !(force_i && i_req);
    eg_i = !reset && i_req && !eg_d;
  endfunction

  function automatic void model_reset();
    exp_iv  = 1'b0;
    exp_dv  = 1'b0;
    exp_ird = 32'h0;
    exp_drd = 32'h0;
    starve  = 0;
  endfunction

  task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                       input logic [3:0] db, input logic [31:0] da, input logic [31:0] dd);
    @(negedge clk);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_be = db; d_addr = da; d_wdata = dd;
    #1;
    predict();
  endtask

  // Clock edge: apply the predicted access to the model, then settle.
  task automatic advance();
    @(posedge clk);
    exp_iv = eg_i;
    exp_dv = eg_d && !d_we;
    if (eg_i) exp_ird = mm[widx(i_addr)];
    if (exp_dv) exp_drd = mm[widx(d_addr)];
    if (eg_d && d_we) begin
      for (int b = 0; b < 4; b++) begin
        if (d_be[b]) mm[widx(d_addr)][8*b +: 8] = d_wdata[8*b +: 8];
      end
    end
    if (!i_req || eg_i) starve = 0;
    else if (starve < STARVE_MAX) starve = starve + 1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0;
    d_be = 4'hF; d_addr = 32'h0; d_wdata = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({i_gnt, d_gnt} !== 2'b00) begin
      failures++; $display("FAIL reset_gnt: got %b want 00", {i_gnt, d_gnt});
    end
    checks++;
    if ({i_rvalid, d_rvalid, i_rdata, d_rdata} !== 66'h0) begin
      failures++;
      $display("FAIL reset_out: got iv=%b dv=%b ird=%h drd=%h want all 0", i_rvalid, d_rvalid, i_rdata, d_rdata);
    end
    @(negedge clk);
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_init();
    for (int w = 0; w < DEPTH; w++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'(w * 4), $urandom);
      checks++;
      if ({i_gnt, d_gnt} !== 2'b01) begin
        failures++; $display("FAIL init_gnt w=%0d: got %b want 01", w, {i_gnt, d_gnt});
      end
      advance();
      checks++;
      if ({i_rvalid, d_rvalid} !== 2'b00) begin
        failures++; $display("FAIL init_rvalid w=%0d: got %b want 00", w, {i_rvalid, d_rvalid});
      end
    end
  endtask

  task automatic test_instr_read();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0C, 32'h00A0_0513);
    advance();
    drive(1'b1, 32'h0C, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if ({i_gnt, d_gnt} !== 2'b10) begin
      failures++; $display("FAIL iread_gnt: got %b want 10", {i_gnt, d_gnt});
    end
    advance();
    checks++;
    if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== 32'h00A0_0513) begin
      failures++;
      $display("FAIL iread_data: got iv=%b dv=%b ird=%h want 1 0 00a00513", i_rvalid, d_rvalid, i_rdata);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    advance();
    checks++;
    if (i_rvalid !== 1'b0 || i_rdata !== 32'h00A0_0513) begin
      failures++; $display("FAIL iread_hold: got iv=%b ird=%h want 0 00a00513", i_rvalid, i_rdata);
    end
  endtask

  task automatic test_contention();
    drive(1'b1, 32'h0C, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    checks++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      failures++; $display("FAIL cont_first: got %b want 01", {i_gnt, d_gnt});
    end
    advance();
    checks++;
    if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== mm[4]) begin
      failures++;
      $display("FAIL cont_d_ret: got dv=%b iv=%b drd=%h want 1 0 %h", d_rvalid, i_rvalid, d_rdata, mm[4]);
    end
    drive(1'b1, 32'h0C, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if ({i_gnt, d_gnt} !== 2'b10) begin
      failures++; $display("FAIL cont_second: got %b want 10", {i_gnt, d_gnt});
    end
    advance();
    checks++;
    if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== mm[3] || d_rdata !== mm[4]) begin
      failures++;
      $display("FAIL cont_i_ret: got iv=%b dv=%b ird=%h drd=%h want 1 0 %h %h",
               i_rvalid, d_rvalid, i_rdata, d_rdata, mm[3], mm[4]);
    end
  endtask

  task automatic test_byte_write();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hFFFF_FFFF);
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0101, 32'h10, 32'h1234_5678);
    advance();
    checks++;
    if (d_rvalid !== 1'b0) begin
      failures++; $display("FAIL bw_no_rvalid: got %b want 0", d_rvalid);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    advance();
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hFF34_FF78) begin
      failures++; $display("FAIL bw_read: got dv=%b drd=%h want 1 ff34ff78", d_rvalid, d_rdata);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0000, 32'h10, 32'hDEAD_BEEF);
    checks++;
    if (d_gnt !== 1'b1) begin
      failures++; $display("FAIL bw_be0_gnt: got %b want 1", d_gnt);
    end
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    advance();
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hFF34_FF78) begin
      failures++; $display("FAIL bw_be0_read: got dv=%b drd=%h want 1 ff34ff78", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0, 32'hCAFE_F00D);
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    advance();
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL wrap_100: got dv=%b drd=%h want 1 cafef00d", d_rvalid, d_rdata);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h4, 32'h0BAD_CAFE);
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h103, 32'h0);
    advance();
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL wrap_103: got dv=%b drd=%h want 1 cafef00d", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_fairness();
    int first_i;
    int exp_first;
    first_i   = 0;
    exp_first = FAIR ? STARVE_MAX + 1 : 0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    advance();
    for (int c = 1; c <= 8; c++) begin
      drive(1'b1, 32'h0C, 1'b1, 1'b0, 4'hF, 32'(4 * c), 32'h0);
      checks++;
      if ({i_gnt, d_gnt} !== {eg_i, eg_d}) begin
        failures++; $display("FAIL fair_gnt c=%0d: got %b want %b", c, {i_gnt, d_gnt}, {eg_i, eg_d});
      end
      if (i_gnt === 1'b1 && first_i == 0) first_i = c;
      advance();
    end
    checks++;
    if (first_i != exp_first) begin
      failures++; $display("FAIL fair_first_igrant: got cycle %0d want %0d", first_i, exp_first);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    advance();
  endtask

  task automatic test_reset_midread();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
    advance();
    checks++;
    if (d_rvalid !== 1'b1) begin
      failures++; $display("FAIL rst_pre_read: got dv=%b want 1", d_rvalid);
    end
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid} !== 4'b0000 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid: got gnt=%b rv=%b ird=%h drd=%h want 00 00 0 0",
               {i_gnt, d_gnt}, {i_rvalid, d_rvalid}, i_rdata, d_rdata);
    end
    @(negedge clk);
    reset = 1'b0; i_req = 1'b1; i_addr = 32'h0C; d_req = 1'b0;
    #1;
    predict();
    checks++;
    if ({i_gnt, d_gnt} !== 2'b10) begin
      failures++; $display("FAIL rst_first_gnt: got %b want 10", {i_gnt, d_gnt});
    end
    advance();
    checks++;
    if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== exp_ird || d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_after: got iv=%b dv=%b ird=%h drd=%h want 1 0 %h 0",
               i_rvalid, d_rvalid, i_rdata, d_rdata, exp_ird);
    end
  endtask

  task automatic test_random();
    bit          ip, dp, dw;
    logic [31:0] ia, da, dd;
    logic [3:0]  db;
    ip = 1'b0; dp = 1'b0; dw = 1'b0;
    ia = 32'h0; da = 32'h0; dd = 32'h0; db = 4'h0;
    for (int n = 0; n < 400; n++) begin
      if (!ip) begin
        ip = ($urandom_range(0, 1) == 1);
        ia = $urandom;
      end
      if (!dp) begin
        dp = ($urandom_range(0, 1) == 1);
        dw = ($urandom_range(0, 1) == 1);
        db = 4'($urandom);
        da = $urandom;
        dd = $urandom;
      end
      drive(ip, ia, dp, dw, db, da, dd);
      checks++;
      if ({i_gnt, d_gnt} !== {eg_i, eg_d}) begin
        failures++; $display("FAIL rnd_gnt n=%0d: got %b want %b", n, {i_gnt, d_gnt}, {eg_i, eg_d});
      end
      advance();
      checks++;
      if ({i_rvalid, d_rvalid} !== {exp_iv, exp_dv}) begin
        failures++;
        $display("FAIL rnd_rvalid n=%0d: got %b want %b", n, {i_rvalid, d_rvalid}, {exp_iv, exp_dv});
      end
      checks++;
      if (i_rdata !== exp_ird || d_rdata !== exp_drd) begin
        failures++;
        $display("FAIL rnd_rdata n=%0d: got i=%h d=%h want i=%h d=%h", n, i_rdata, d_rdata, exp_ird, exp_drd);
      end
      if (eg_i) ip = 1'b0;
      if (eg_d) dp = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_instr_read();
    test_contention();
    test_byte_write();
    test_wrap();
    test_fairness();
    test_reset_midread();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, word-address width (64 x 32-bit words, 256 bytes).
REQ-002 SHALL have parameter STARVE_MAX, default 4, consecutive denied instruction-request cycles before forced instruction grant.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports i_req in 1, i_addr in 32 (byte address): instruction-fetch request.
REQ-006 SHALL have ports i_gnt out 1, i_rvalid out 1, i_rdata out 32: instruction grant and read return.
REQ-007 SHALL have ports d_req in 1, d_we in 1, d_be in 4, d_addr in 32, d_wdata in 32: data request.
REQ-008 SHALL have ports d_gnt out 1, d_rvalid out 1, d_rdata out 32: data grant and read return.

Function
REQ-009 SHALL share one single-port synchronous RAM between the instruction and data requesters, at most one access per cycle.
REQ-010 SHALL decode word index = addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 ignored (wrap-around, no error).
REQ-011 SHALL assert gnt combinationally in the cycle a request is accepted; requester holds req/addr/wdata stable until gnt.
REQ-012 SHALL give data priority over instruction when both request, except when fairness forces instruction (REQ-024).
REQ-013 SHALL implement FSM states IDLE, I_RD, D_RD, D_WR, next state = outcome of this cycle's arbitration (none -> IDLE).
REQ-014 SHALL assert i_rvalid exactly when state is I_RD and d_rvalid exactly when state is D_RD: read latency 1 cycle after gnt.
REQ-015 SHALL hold i_rdata/d_rdata at last returned value when rvalid low.
REQ-016 SHALL perform data writes in the grant cycle, updating only bytes with d_be[n]=1; d_we=1 with d_be=0 granted, no change; no rvalid.
REQ-017 SHALL support back-to-back grants every cycle; read immediately following write to same word returns new data.
REQ-018 SHALL never assert i_gnt and d_gnt in the same cycle.
REQ-019 SHALL assert no gnt while reset high.

Reset
REQ-020 SHALL on reset assertion immediately force state IDLE, i_gnt=d_gnt=i_rvalid=d_rvalid=0, i_rdata=d_rdata=0, starvation counter 0.
REQ-021 SHALL drop any read in flight when reset asserts mid-operation; no rvalid after deassertion for it.
REQ-022 SHALL not reset RAM contents; RAM preloadable by the program-load mechanism used by the core.
REQ-023 SHALL accept requests on the first rising edge after reset deassertion.

Configuration
REQ-024 With MEM_ARBITER_FAIRNESS_EN defined: SHALL count consecutive cycles i_req=1 and i_gnt=0, saturating at STARVE_MAX; when count=STARVE_MAX, instruction wins next contention; counter clears on i_gnt or i_req=0.
REQ-025 Without MEM_ARBITER_FAIRNESS_EN: SHALL use strict data priority, no counter logic synthesised.

Structure
REQ-026 SHALL place FSM state encoding, opcode-independent access-type constants and default ADDR_W in shared package cpu_pkg.
REQ-027 SHALL instantiate RAM as sub-module mem_sp (1 read/write port, byte enables, 1-cycle read latency).

Verification
REQ-028 Reset: assert reset mid-read -> i_rvalid/d_rvalid 0, all rdata 0; first request after deassert granted same cycle.
REQ-029 Instruction read: preload word 3=0x00A00513, i_req, i_addr=0x0C -> i_gnt cycle N, i_rvalid cycle N+1, i_rdata=0x00A00513.
REQ-030 Contention: i_req and d_req (read 0x10) same cycle -> d_gnt first, i_gnt next cycle, rvalids in order D then I.
REQ-031 Byte write: word 4=0xFFFFFFFF, write d_be=4'b0101 d_wdata=0x12345678 -> read 0x10 returns 0xFF34FF78.
REQ-032 Wrap: d_addr=0x100 reads word 0; d_addr=0x103 reads word 0.
REQ-033 Fairness (macro on, STARVE_MAX=4): d_req held every cycle, i_req held -> i_gnt in 5th cycle; macro off -> i_gnt never while d_req high.
